// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, grant owner and
// counter widths used by mem_port_arbiter and mem_arb_picker.
package mem_arb_pkg;

  localparam int LAT_CNT_W    = 4;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic owner_e to_owner(input logic grant_if);
    return grant_if ? OWN_IF : OWN_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bus of the arbiter. The slave modport is the
// arbiter's view; the master modport is the surrounding datapath plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  // Shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Grant decision for the shared memory port. Default build: D priority with a
// starvation guard for IF. With ARB_ROUND_ROBIN_EN defined: two-way round robin.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic grant_vld_o,
  output logic grant_if_o
);

  logic grant_if;

  assign grant_vld_o = arb_en_i && (if_req_i || d_req_i);
  assign grant_if_o  = grant_if;

`ifdef ARB_ROUND_ROBIN_EN

  // Owner of the previous grant; resets to D so IF wins the first contest.
  owner_e last_q, last_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    last_d   = last_q;
    grant_if = if_req_i && (!d_req_i || (last_q == OWN_D));
    if (grant_vld_o) begin
      last_d = to_owner(grant_if);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end

`else

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    starve_hit;

  assign starve_hit = (starve_q == STARVE_LIM);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    starve_d = starve_q;
    grant_if = if_req_i && (!d_req_i || starve_hit);
    // Only an actual arbitration in which IF asks for the port counts.
    if (arb_en_i && if_req_i) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (!starve_hit) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data_memory port between the IF and D requesters with a fixed
// MEM_LAT access. Optional round-robin arbitration via ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic [LAT_CNT_W-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]      d_rdata_q, d_rdata_d;

  logic                   grant_vld;
  logic                   grant_if;
  logic                   in_access;
  logic                   in_resp;

  mem_arb_picker #(
    .STARVE_MAX (STARVE_MAX)
  ) u_picker (
    .clk         (clk),
    .reset_n     (reset_n),
    .arb_en_i    (state_q == IDLE),
    .if_req_i    (bus.if_req),
    .d_req_i     (bus.d_req),
    .grant_vld_o (grant_vld),
    .grant_if_o  (grant_if)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = to_owner(grant_if);
          lat_d   = LAT_INIT;
          state_d = ACCESS;
          if (grant_if) begin
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end
        end
      end

      ACCESS: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus.mem_rdata;
          end else begin
            d_rdata_d = we_q ? '0 : bus.mem_rdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      // Requests still pending here are arbitrated next cycle, in IDLE.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_D;
      lat_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      // NOTE: the rdata holding registers are reset too, because every
      // output must read 0 while reset_n is low.
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from the values present before the clock edge.
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // The write strobe is a single pulse in the first ACCESS cycle.
  assign bus.mem_en    = in_access;
  assign bus.mem_we    = in_access && we_q && (lat_q == LAT_INIT);
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

  assign bus.if_ready  = in_resp && (owner_q == OWN_IF);
  assign bus.d_ready   = in_resp && (owner_q == OWN_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
